// File: rtl/noc_local_arbiter_if.sv
// Requester-side and router-side flit handshake bundle for noc_local_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface noc_local_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned FLIT_W = 16
);
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*FLIT_W-1:0] req_flit_i;
  logic [N_REQ-1:0]        req_last_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [FLIT_W-1:0]       local_o;
  logic                    valid_l_o;
  logic                    incr_i;

  modport slave (
    input  req_valid_i, req_flit_i, req_last_i, incr_i,
    output req_ready_o, local_o, valid_l_o
  );

  modport master (
    output req_valid_i, req_flit_i, req_last_i, incr_i,
    input  req_ready_o, local_o, valid_l_o
  );
endinterface

// File: rtl/noc_local_arbiter.sv
// noc_local_arbiter: round-robin, packet-atomic sharing of one router local
// injection port among N_REQ requesters, with credit tracking for the router's
// local input buffer. Optional per-requester packet counters are built when the
// NOC_ARB_STATS_EN macro is defined.
module noc_local_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned FLIT_W  = 16,
  parameter int unsigned CREDITS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  noc_local_arbiter_if.slave               bus,
  output logic [N_REQ-1:0]                 grant_o,
  output logic [$clog2(CREDITS+1)-1:0]     credit_o,
  output logic                             cred_err_o
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]              pkt_cnt_o,
  input  logic                             stats_clr_i
`endif
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       rr_q, rr_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [CW-1:0]       credit_q, credit_d;
  logic                err_q, err_d;
  logic [FLIT_W-1:0]   local_q, local_d;
  logic                valid_q, valid_d;

  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       sel_idx;
  logic                sel_last;
  logic [FLIT_W-1:0]   sel_flit;
  logic [N_REQ-1:0]    ready_c;
  logic                accept;

  // Index base+off wrapped modulo N_REQ.
  function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= int'(N_REQ)) s = s - int'(N_REQ);
    return PW'(s);
  endfunction

  // Round-robin search: first valid requester at or after rr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (bus.req_valid_i[rot_idx(rr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = rot_idx(rr_q, k);
      end
    end
  end

  // Requester currently eligible for the port: the holder when locked, else the winner.
  always_comb begin
    sel_idx  = (state_q == S_LOCKED) ? gidx_q : win_idx;
    sel_last = bus.req_last_i[sel_idx];
    sel_flit = bus.req_flit_i[int'(sel_idx)*int'(FLIT_W) +: FLIT_W];
  end

  // Arbitration FSM next state, grant and ready generation.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    ready_c = '0;
    case (state_q)
      S_IDLE: begin
        if ((credit_q != '0) && win_found) begin
          ready_c[sel_idx] = 1'b1;
          if (sel_last) begin
            rr_d = rot_idx(sel_idx, 1);
          end else begin
            state_d          = S_LOCKED;
            gidx_d           = sel_idx;
            grant_d          = '0;
            grant_d[sel_idx] = 1'b1;
          end
        end
      end
      S_LOCKED: begin
        if ((credit_q != '0) && bus.req_valid_i[sel_idx]) begin
          ready_c[sel_idx] = 1'b1;
          if (sel_last) begin
            state_d = S_IDLE;
            grant_d = '0;
            rr_d    = rot_idx(sel_idx, 1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign accept = |ready_c;

  // Credit accounting and sticky overflow flag.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (accept && !bus.incr_i) begin
      credit_d = credit_q - CW'(1);
    end else if (!accept && bus.incr_i) begin
      if (credit_q == CW'(CREDITS)) err_d = 1'b1;
      else                          credit_d = credit_q + CW'(1);
    end
  end

  // One-cycle flit pipeline toward the router.
  always_comb begin
    local_d = accept ? sel_flit : local_q;
    valid_d = accept;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      credit_q <= CW'(CREDITS);
      err_q    <= 1'b0;
      local_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      local_q  <= local_d;
      valid_q  <= valid_d;
    end
  end

  // Ready is forced low while reset is asserted, even with requesters valid.
  assign bus.req_ready_o = rst ? ready_c : '0;
  assign bus.local_o     = local_q;
  assign bus.valid_l_o   = valid_q;
  assign grant_o         = grant_q;
  assign credit_o        = credit_q;
  assign cred_err_o      = err_q;

`ifdef NOC_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] cnt_q, cnt_d;

  // Saturating per-requester packet counters; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (stats_clr_i) begin
      cnt_d = '0;
    end else if (accept && sel_last && (cnt_q[sel_idx] != 16'hFFFF)) begin
      cnt_d[sel_idx] = cnt_q[sel_idx] + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign pkt_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_noc_local_arbiter.sv
// Directed, table-driven bench for noc_local_arbiter (counter checks built when
// NOC_ARB_STATS_EN is defined).
module tb_noc_local_arbiter;
  localparam int unsigned N_REQ   = 4;
  localparam int unsigned FLIT_W  = 16;
  localparam int unsigned CREDITS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] grant;
  logic [2:0] credit;
  logic       cred_err;
`ifdef NOC_ARB_STATS_EN
  logic [63:0] pkt_cnt;
  logic        stats_clr = 1'b0;
`endif

  noc_local_arbiter_if #(.N_REQ(N_REQ), .FLIT_W(FLIT_W)) bus ();

  noc_local_arbiter #(.N_REQ(N_REQ), .FLIT_W(FLIT_W), .CREDITS(CREDITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .grant_o    (grant),
    .credit_o   (credit),
    .cred_err_o (cred_err)
`ifdef NOC_ARB_STATS_EN
    ,
    .pkt_cnt_o  (pkt_cnt),
    .stats_clr_i(stats_clr)
`endif
  );

  always #5 clk = ~clk;

  // Inputs applied in a cycle and the outputs expected in that same cycle
  // (ready is combinational; the rest reflect the previous clock edge).
  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [63:0] f;
    logic        incr;
    logic [3:0]  rdy;
    logic        vl;
    logic [15:0] loc;
    logic [3:0]  gnt;
    logic [2:0]  cr;
    logic        err;
  } vec_t;

  vec_t vecs [30];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [63:0] f, input logic incr);
    bus.req_valid_i = v;
    bus.req_last_i  = l;
    bus.req_flit_i  = f;
    bus.incr_i      = incr;
  endtask

  initial begin
    // single flit, then 3-flit packets from req1/req2 with credit returns
    vecs[0]  = '{4'h1, 4'h1, 64'h0000_0000_0000_A5A5, 1'b0, 4'h1, 1'b0, 16'h0000, 4'h0, 3'd4, 1'b0};
    vecs[1]  = '{4'h0, 4'h0, 64'h0,                   1'b0, 4'h0, 1'b1, 16'hA5A5, 4'h0, 3'd3, 1'b0};
    vecs[2]  = '{4'h6, 4'h0, 64'h0000_2201_1101_0000, 1'b0, 4'h2, 1'b0, 16'hA5A5, 4'h0, 3'd3, 1'b0};
    vecs[3]  = '{4'h6, 4'h0, 64'h0000_2201_1102_0000, 1'b1, 4'h2, 1'b1, 16'h1101, 4'h2, 3'd2, 1'b0};
    vecs[4]  = '{4'h6, 4'h2, 64'h0000_2201_1103_0000, 1'b1, 4'h2, 1'b1, 16'h1102, 4'h2, 3'd2, 1'b0};
    vecs[5]  = '{4'h4, 4'h0, 64'h0000_2201_0000_0000, 1'b1, 4'h4, 1'b1, 16'h1103, 4'h0, 3'd2, 1'b0};
    vecs[6]  = '{4'h4, 4'h0, 64'h0000_2202_0000_0000, 1'b1, 4'h4, 1'b1, 16'h2201, 4'h4, 3'd2, 1'b0};
    vecs[7]  = '{4'h4, 4'h4, 64'h0000_2203_0000_0000, 1'b1, 4'h4, 1'b1, 16'h2202, 4'h4, 3'd2, 1'b0};
    vecs[8]  = '{4'h0, 4'h0, 64'h0,                   1'b1, 4'h0, 1'b1, 16'h2203, 4'h0, 3'd2, 1'b0};
    vecs[9]  = '{4'h0, 4'h0, 64'h0,                   1'b1, 4'h0, 1'b0, 16'h2203, 4'h0, 3'd3, 1'b0};
    // req0 streams 6 flits with credits running out; req1 must stay blocked
    vecs[10] = '{4'h1, 4'h0, 64'h0000_0000_0000_0A01, 1'b0, 4'h1, 1'b0, 16'h2203, 4'h0, 3'd4, 1'b0};
    vecs[11] = '{4'h1, 4'h0, 64'h0000_0000_0000_0A02, 1'b0, 4'h1, 1'b1, 16'h0A01, 4'h1, 3'd3, 1'b0};
    vecs[12] = '{4'h1, 4'h0, 64'h0000_0000_0000_0A03, 1'b0, 4'h1, 1'b1, 16'h0A02, 4'h1, 3'd2, 1'b0};
    vecs[13] = '{4'h1, 4'h0, 64'h0000_0000_0000_0A04, 1'b0, 4'h1, 1'b1, 16'h0A03, 4'h1, 3'd1, 1'b0};
    vecs[14] = '{4'h3, 4'h0, 64'h0000_0000_1B01_0A05, 1'b0, 4'h0, 1'b1, 16'h0A04, 4'h1, 3'd0, 1'b0};
    vecs[15] = '{4'h3, 4'h0, 64'h0000_0000_1B01_0A05, 1'b1, 4'h0, 1'b0, 16'h0A04, 4'h1, 3'd0, 1'b0};
    vecs[16] = '{4'h3, 4'h0, 64'h0000_0000_1B01_0A05, 1'b0, 4'h1, 1'b0, 16'h0A04, 4'h1, 3'd1, 1'b0};
    vecs[17] = '{4'h3, 4'h1, 64'h0000_0000_1B01_0A06, 1'b0, 4'h0, 1'b1, 16'h0A05, 4'h1, 3'd0, 1'b0};
    vecs[18] = '{4'h3, 4'h1, 64'h0000_0000_1B01_0A06, 1'b1, 4'h0, 1'b0, 16'h0A05, 4'h1, 3'd0, 1'b0};
    vecs[19] = '{4'h3, 4'h1, 64'h0000_0000_1B01_0A06, 1'b1, 4'h1, 1'b0, 16'h0A05, 4'h1, 3'd1, 1'b0};
    // back-to-back single-flit packets from different requesters
    vecs[20] = '{4'h2, 4'h2, 64'h0000_0000_1B01_0000, 1'b1, 4'h2, 1'b1, 16'h0A06, 4'h0, 3'd1, 1'b0};
    vecs[21] = '{4'hC, 4'hC, 64'h3C01_2C01_0000_0000, 1'b1, 4'h4, 1'b1, 16'h1B01, 4'h0, 3'd1, 1'b0};
    vecs[22] = '{4'h8, 4'h8, 64'h3C01_0000_0000_0000, 1'b1, 4'h8, 1'b1, 16'h2C01, 4'h0, 3'd1, 1'b0};
    // refill to full, then overflow sets the sticky error
    vecs[23] = '{4'h0, 4'h0, 64'h0,                   1'b1, 4'h0, 1'b1, 16'h3C01, 4'h0, 3'd1, 1'b0};
    vecs[24] = '{4'h0, 4'h0, 64'h0,                   1'b1, 4'h0, 1'b0, 16'h3C01, 4'h0, 3'd2, 1'b0};
    vecs[25] = '{4'h0, 4'h0, 64'h0,                   1'b1, 4'h0, 1'b0, 16'h3C01, 4'h0, 3'd3, 1'b0};
    vecs[26] = '{4'h0, 4'h0, 64'h0,                   1'b1, 4'h0, 1'b0, 16'h3C01, 4'h0, 3'd4, 1'b0};
    vecs[27] = '{4'h0, 4'h0, 64'h0,                   1'b0, 4'h0, 1'b0, 16'h3C01, 4'h0, 3'd4, 1'b1};
    vecs[28] = '{4'h1, 4'h1, 64'h0000_0000_0000_0D01, 1'b0, 4'h1, 1'b0, 16'h3C01, 4'h0, 3'd4, 1'b1};
    vecs[29] = '{4'h0, 4'h0, 64'h0,                   1'b0, 4'h0, 1'b1, 16'h0D01, 4'h0, 3'd3, 1'b1};

    drive(4'h0, 4'h0, 64'h0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset valid_l", 64'(bus.valid_l_o), 64'h0);
    chk("reset credit",  64'(credit),        64'd4);
    chk("reset local",   64'(bus.local_o),   64'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].l, vecs[i].f, vecs[i].incr);
      #1;
      chk($sformatf("row%0d ready",   i), 64'(bus.req_ready_o), 64'(vecs[i].rdy));
      chk($sformatf("row%0d valid_l", i), 64'(bus.valid_l_o),   64'(vecs[i].vl));
      chk($sformatf("row%0d local",   i), 64'(bus.local_o),     64'(vecs[i].loc));
      chk($sformatf("row%0d grant",   i), 64'(grant),           64'(vecs[i].gnt));
      chk($sformatf("row%0d credit",  i), 64'(credit),          64'(vecs[i].cr));
      chk($sformatf("row%0d err",     i), 64'(cred_err),        64'(vecs[i].err));
    end

    // asynchronous reset in the middle of a 4-flit packet from req0
    @(negedge clk);
    drive(4'h1, 4'h0, 64'h0000_0000_0000_0E01, 1'b0);
    #1;
    chk("abort flit1 ready", 64'(bus.req_ready_o), 64'h1);
    @(negedge clk);
    drive(4'h1, 4'h0, 64'h0000_0000_0000_0E02, 1'b0);
    #1;
    chk("abort flit2 grant", 64'(grant),         64'h1);
    chk("abort flit2 local", 64'(bus.local_o),   64'h0E01);
    @(negedge clk);
    drive(4'h1, 4'h0, 64'h0000_0000_0000_0E03, 1'b0);
    #1;
    chk("abort pre valid_l", 64'(bus.valid_l_o), 64'h1);
    chk("abort pre credit",  64'(credit),        64'd1);
    rst = 1'b0;
    #1;
    chk("abort valid_l", 64'(bus.valid_l_o),   64'h0);
    chk("abort grant",   64'(grant),           64'h0);
    chk("abort credit",  64'(credit),          64'd4);
    chk("abort err",     64'(cred_err),        64'h0);
    chk("abort local",   64'(bus.local_o),     64'h0);
    chk("abort ready",   64'(bus.req_ready_o), 64'h0);
    drive(4'h0, 4'h0, 64'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

`ifdef NOC_ARB_STATS_EN
    // five single-flit packets from req3, then a clear colliding with a sixth
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(4'h8, 4'h8, {16'(16'h3F00 + k), 48'h0}, 1'b1);
      #1;
      chk($sformatf("stats pkt%0d ready", k), 64'(bus.req_ready_o), 64'h8);
    end
    @(negedge clk);
    drive(4'h0, 4'h0, 64'h0, 1'b0);
    #1;
    chk("stats cnt3",   64'(pkt_cnt[63:48]), 64'd5);
    chk("stats others", 64'(pkt_cnt[47:0]),  64'h0);
    chk("stats credit", 64'(credit),         64'd4);
    @(negedge clk);
    drive(4'h8, 4'h8, 64'h3F05_0000_0000_0000, 1'b1);
    stats_clr = 1'b1;
    #1;
    chk("stats clr ready", 64'(bus.req_ready_o), 64'h8);
    @(negedge clk);
    drive(4'h0, 4'h0, 64'h0, 1'b0);
    stats_clr = 1'b0;
    #1;
    chk("stats cleared", 64'(pkt_cnt), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/noc_local_arbiter.md
Name: noc_local_arbiter

Overview:
Shares one router local injection port among N_REQ on-tile requesters, so several sources can inject into the 4x4 mesh through a single node. Does round-robin arbitration with packet-atomic grants: once a requester wins, it keeps the port until its last flit is accepted. Tracks credits for the router's local input buffer and never sends a flit without a credit. Outputs drive the router's local_i and valid_l_i; the router's l_incr_o drives incr_i.

Parameters:
N_REQ, 4, number of requesters (2..8)
FLIT_W, 16, flit width in bits
CREDITS, 4, depth of the router local input buffer, which is also the initial credit count

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_valid_i  in  N_REQ  per-requester flit valid
req_flit_i  in  N_REQ*FLIT_W  per-requester flit; requester i uses bits [i*FLIT_W +: FLIT_W]
req_last_i  in  N_REQ  per-requester flag: current flit is the last flit of its packet
req_ready_o  out  N_REQ  per-requester flit accepted this cycle (combinational)
local_o  out  FLIT_W  registered flit to the router local input
valid_l_o  out  1  registered valid to the router local input
incr_i  in  1  one-cycle credit return pulse from the router
grant_o  out  N_REQ  one-hot grant currently held; zero when IDLE
credit_o  out  clog2(CREDITS+1)  current credit count
cred_err_o  out  1  sticky error: credit overflow
(ports present only with NOC_ARB_STATS_EN) pkt_cnt_o  out  N_REQ*16  per-requester packet counters; stats_clr_i  in  1  synchronous clear of the counters

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0, credits=CREDITS, local_o=0, valid_l_o=0, grant_o=0, cred_err_o=0, req_ready_o=0.
- accept = a req_ready_o bit is high. req_ready_o[i] is high only when req_valid_i[i] is high and credits>0. At most one bit is high per cycle.
- IDLE:
  - If credits>0 and any req_valid_i is set: the winner is the first set index searched from rr_ptr upward, wrapping modulo N_REQ.
  - The winner's first flit is accepted in the same cycle.
  - If that flit has req_last_i=1: stay in IDLE and set rr_ptr = winner+1 mod N_REQ.
  - Otherwise: go to LOCKED and latch grant_o = onehot(winner).
- LOCKED:
  - Only the granted requester can be accepted. Other requesters see ready=0 even if credits are available.
  - On accepting a flit with req_last_i=1: go to IDLE, grant_o=0, rr_ptr = granted+1 mod N_REQ.
  - If the granted requester drops valid, the grant is held indefinitely (no timeout).
- Datapath latency is 1 cycle. On an accept in cycle t, local_o equals the accepted flit and valid_l_o=1 in cycle t+1. With no accept, valid_l_o=0 and local_o holds its last value.
- Credits:
  - Decrement on accept, increment on incr_i.
  - Accept and incr_i in the same cycle: credits unchanged.
  - With credits=0, no accept is possible. incr_i in that cycle lets the next cycle accept.
  - incr_i while credits==CREDITS with no accept: credits stay at CREDITS and cred_err_o sets. cred_err_o clears only on reset.
- Back-to-back single-flit packets from different requesters are accepted on consecutive cycles, with no bubble.
- Reset mid-packet aborts the packet. The router-side flush is the system's responsibility.

Optional Feature:
NOC_ARB_STATS_EN:
- Defined:
  - Adds pkt_cnt_o and stats_clr_i.
  - Counter i increments on accept of requester i's last flit.
  - Counters saturate at 16'hFFFF.
  - stats_clr_i zeroes all counters and takes priority over an increment in the same cycle.
  - Counters reset to 0.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
1. Reset, then req0 sends flit 16'hA5A5 with last=1 -> ready[0]=1 in the same cycle; next cycle local_o=A5A5 and valid_l_o=1; credit_o=3; rr_ptr=1.
2. req1 and req2 each present a 3-flit packet at the same time, rr_ptr=1, with incr_i pulsed 1 cycle after each send -> the 3 req1 flits are contiguous and grant_o=0010 throughout; then the 3 req2 flits follow; no interleaving.
3. CREDITS=4, no incr_i, req0 streams 6 flits -> 4 accepts, then ready=0 and credit_o=0; one incr_i pulse -> exactly one more accept the next cycle.
4. credit_o=2 and an accept coincides with incr_i -> credit_o stays 2. credit_o=4 and incr_i with no accept -> credit_o=4 and cred_err_o=1 sticky until rst.
5. rst asserted low during LOCKED on flit 2 of 4 -> valid_l_o=0, grant_o=0 and credit_o=4 immediately, without waiting for a clock edge.
6. With NOC_ARB_STATS_EN defined, req3 sends 5 single-flit packets -> pkt_cnt_o[63:48]=5; stats_clr_i together with a 6th last-flit accept -> count=0.
